// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared core package for the writeback path.
// Provides the default register-file geometry, the requester ids used by the
// writeback arbiter and the width of the committed-write counter.
package regfile_wb_arbiter_pkg;

  localparam int ADDR_WIDTH_DEF = 5;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int WB_CNT_WIDTH   = 16;

  typedef enum logic {
    REQ_EXU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;

  // One-hot grant vector for a requester id.
  function automatic logic [1:0] req_onehot(input req_id_e id);
    return (id == REQ_LSU) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin choice for the writeback arbiter.
// Ports:
//   en    - the output stage can load this cycle; no grant when low
//   valid - request valids, bit index = requester id
//   last  - requester that won the most recent completed handshake
//   grant - one-hot grant, all zero when nothing is granted
module rr_arb2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic       en,
  input  logic [1:0] valid,
  input  req_id_e    last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (en) begin
      unique case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        // Tie goes to whoever did not win last time.
        2'b11:   grant = req_onehot((last == REQ_EXU) ? REQ_LSU : REQ_EXU);
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter in front of a single register-file write port.
// Two requesters (0 = EXU, 1 = LSU) compete through a round-robin arbiter
// for one output stage; the stage drives the register-file write port and
// is frozen while hold is high. Writes to index 0 are accepted but dropped.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   reqN_valid/rd/data          - writeback request from requester N
//   reqN_ready                  - request N accepted this cycle
//   hold                        - register-file write port unavailable
//   wen, rd, dataD              - register-file write port
//   wr_count                    - committed nonzero-index writes (wraps)
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0_valid,
  input  logic [ADDR_WIDTH-1:0]   req0_rd,
  input  logic [DATA_WIDTH-1:0]   req0_data,
  output logic                    req0_ready,
  input  logic                    req1_valid,
  input  logic [ADDR_WIDTH-1:0]   req1_rd,
  input  logic [DATA_WIDTH-1:0]   req1_data,
  output logic                    req1_ready,
  input  logic                    hold,
  output logic                    wen,
  output logic [ADDR_WIDTH-1:0]   rd,
  output logic [DATA_WIDTH-1:0]   dataD,
  output logic [WB_CNT_WIDTH-1:0] wr_count
);

  logic                  out_valid;
  logic [ADDR_WIDTH-1:0] out_rd;
  logic [DATA_WIDTH-1:0] out_data;
  req_id_e               last_grant;

  logic       can_load;
  logic [1:0] grant;
  logic       handshake;
  logic       retire;

  // The stage can take a new entry when empty or when it drains this cycle.
  assign can_load = ~rst & (~out_valid | ~hold);

  rr_arb2 u_rr_arb2 (
    .en    (can_load),
    .valid ({req1_valid, req0_valid}),
    .last  (last_grant),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign handshake  = |grant;
  assign retire     = out_valid & ~hold;

  assign wen   = ~rst & retire & (out_rd != '0);
  assign rd    = out_rd;
  assign dataD = out_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_rd     <= '0;
      out_data   <= '0;
      last_grant <= REQ_LSU;
      wr_count   <= '0;
    end else begin
      if (handshake) begin
        out_valid  <= 1'b1;
        out_rd     <= grant[1] ? req1_rd   : req0_rd;
        out_data   <= grant[1] ? req1_data : req0_data;
        last_grant <= grant[1] ? REQ_LSU   : REQ_EXU;
      end else if (retire) begin
        out_valid <= 1'b0;
      end
      if (wen) begin
        wr_count <= wr_count + WB_CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [4:0]  req0_rd = '0, req1_rd = '0;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready;
  logic        hold = 1'b0;
  logic        wen;
  logic [4:0]  rd;
  logic [31:0] dataD;
  logic [15:0] wr_count;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
    .hold(hold), .wen(wen), .rd(rd), .dataD(dataD), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: one staged write, who won last tie-break, commit count.
  bit          m_valid;
  bit [4:0]    m_rd;
  bit [31:0]   m_data;
  int          m_last;
  int unsigned m_cnt;
  bit          g0, g1, obs_r0, obs_r1, obs_wen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_valid = 0; m_rd = 0; m_data = 0; m_last = 1; m_cnt = 0;
  endtask

  // One clock: check outputs mid-low-phase against the model, then advance it.
  task automatic cycle();
    bit can, exp_wen;
    @(negedge clk); #1;
    can = !m_valid || !hold;
    g0 = 0; g1 = 0;
    if (can) begin
      if (req0_valid && req1_valid) begin
        if (m_last == 0) g1 = 1; else g0 = 1;
      end else begin
        g0 = req0_valid; g1 = req1_valid;
      end
    end
    exp_wen = m_valid && !hold && (m_rd != 0);
    obs_r0 = req0_ready; obs_r1 = req1_ready; obs_wen = wen;
    chk("ready0", req0_ready, g0);
    chk("ready1", req1_ready, g1);
    chk("wen", wen, exp_wen);
    chk("rd", rd, m_rd);
    chk("dataD", dataD, m_data);
    chk("wr_count", wr_count, m_cnt % 65536);
    if (exp_wen) m_cnt++;
    if (g0 || g1) begin
      m_valid = 1;
      m_rd    = g1 ? req1_rd : req0_rd;
      m_data  = g1 ? req1_data : req0_data;
      m_last  = g1 ? 1 : 0;
    end else if (m_valid && !hold) begin
      m_valid = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1; #1;
    chk("rst_wen_now", wen, 0);
    req0_valid = 1; req1_valid = 1; hold = 0;
    @(posedge clk); #1;
    @(negedge clk); #1;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_wen", wen, 0);
    @(posedge clk); #1;
    rst = 0; req0_valid = 0; req1_valid = 0;
    model_reset();
    chk("rst_cnt", wr_count, 0);
    chk("rst_rd", rd, 0);
    chk("rst_data", dataD, 0);
  endtask

  task automatic idle();
    req0_valid = 0; req1_valid = 0; hold = 0;
  endtask

  initial begin
    bit p0, p1;
    int grants[4];
    int wen_cnt;

    model_reset();
    do_reset();

    // Lone EXU request
    req0_valid = 1; req0_rd = 3; req0_data = 32'h1234_5678;
    cycle();
    chk("single_ready", obs_r0, 1);
    idle();
    cycle();
    chk("single_wen", obs_wen, 1);
    chk("single_rd", rd, 3);
    chk("single_data", dataD, 32'h1234_5678);
    cycle();
    chk("single_cnt", wr_count, 1);

    // Both valid for 4 cycles after reset: grants alternate starting with 0
    do_reset();
    wen_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      req0_valid = (i < 4); req1_valid = (i < 4);
      req0_rd = 5'(i + 1);  req0_data = 32'hA000_0000 + i;
      req1_rd = 5'(i + 10); req1_data = 32'hB000_0000 + i;
      cycle();
      if (i < 4) grants[i] = obs_r1 ? 1 : 0;
      if (i > 0) wen_cnt += obs_wen ? 1 : 0;
    end
    chk("rr_g0", grants[0], 0);
    chk("rr_g1", grants[1], 1);
    chk("rr_g2", grants[2], 0);
    chk("rr_g3", grants[3], 1);
    chk("rr_wen_run", wen_cnt, 4);
    idle(); cycle();

    // Stage full, hold for 3 cycles with both requesting
    req0_valid = 1; req0_rd = 7; req0_data = 32'hC0DE_0007;
    cycle();
    req1_valid = 1; req1_rd = 9; req1_data = 32'hC0DE_0009;
    req0_rd = 8; req0_data = 32'hC0DE_0008;
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("hold_ready", {obs_r0, obs_r1}, 2'b00);
      chk("hold_wen", obs_wen, 0);
      chk("hold_rd", rd, 7);
    end
    hold = 0;
    cycle();
    chk("hold_release_wen", obs_wen, 1);
    idle(); cycle(); cycle();

    // Index 0 write from LSU: accepted, never committed
    begin
      logic [15:0] c0;
      c0 = wr_count;
      req1_valid = 1; req1_rd = 0; req1_data = 32'hFFFF_FFFF;
      cycle();
      chk("r0_ready", obs_r1, 1);
      idle();
      cycle();
      chk("r0_wen", obs_wen, 0);
      cycle();
      chk("r0_cnt", wr_count, c0);
    end

    // Handshake then reset: staged write discarded, pointer back to 1
    req0_valid = 1; req0_rd = 5; req0_data = 32'h5555_5555;
    cycle();
    do_reset();
    chk("rst_mid_cnt", wr_count, 0);
    cycle();
    chk("rst_mid_wen", obs_wen, 0);
    req0_valid = 1; req1_valid = 1; req0_rd = 2; req1_rd = 4;
    cycle();
    chk("rst_ptr_tie", {obs_r1, obs_r0}, 2'b01);
    idle(); cycle(); cycle();

    // Randomised traffic with stable-until-ready requesters
    do_reset();
    p0 = 0; p1 = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!p0 && $urandom_range(0, 2) != 0) begin
        p0 = 1; req0_rd = 5'($urandom_range(0, 31)); req0_data = $urandom;
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1; req1_rd = 5'($urandom_range(0, 31)); req1_data = $urandom;
      end
      req0_valid = p0; req1_valid = p1;
      hold = ($urandom_range(0, 3) == 0);
      cycle();
      if (obs_r0) p0 = 0;
      if (obs_r1) p1 = 0;
    end
    idle(); cycle(); cycle();

    // 65536 committed writes wrap the counter back to 0
    do_reset();
    req0_valid = 1; req0_rd = 1; req0_data = 32'h0000_0001;
    for (int i = 0; i < 65536; i++) cycle();
    idle();
    cycle();
    cycle();
    chk("wrap_cnt", wr_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
